// File: rtl/dds_pkg.sv
// Shared DDS definitions: quarter-wave LUT geometry and loader state encoding.
package dds_pkg;
  localparam int LUT_ADDR_W     = 9;
  localparam int LUT_DATA_W     = 16;
  localparam int LUT_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } lut_ld_state_e;
endpackage

// File: rtl/lut_rd_tag_pipe.sv
// Valid+address delay line matching the BRAM read latency, so each returned
// word arrives tagged with the address it was read from.
module lut_rd_tag_pipe
  import dds_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DEPTH  = LUT_RD_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);
  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];

  // Shift tags one stage per cycle; a flush drops every in-flight read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_vld <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= {ADDR_W{1'b0}};
    end else begin
      r_vld[0]  <= i_valid;
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];
endmodule

// File: rtl/quarter_sine_lut_loader.sv
// Loads the quarter-wave sine LUT from a sample stream, reads it back to verify
// checksum and monotonic order, and only then flags the LUT as valid.
module quarter_sine_lut_loader
  import dds_pkg::*;
#(
  parameter int ADDR_W     = LUT_ADDR_W,
  parameter int DATA_W     = LUT_DATA_W,
  parameter int RD_LATENCY = LUT_RD_LATENCY,
  parameter bit CHECK_MONO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_lut_valid,
  output logic              o_error,
  output logic [DATA_W-1:0] o_checksum
);
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  lut_ld_state_e     r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_load_last;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_checksum;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rb_sum;
  logic [DATA_W-1:0] r_rb_prev;
  logic              r_rb_mono_fail;

  logic              w_accept;
  logic              w_mono_fail;
  logic              w_issue;
  logic              w_tag_vld;
  logic [ADDR_W-1:0] w_tag_addr;
  logic              w_tag_last;
  logic [DATA_W-1:0] w_rb_next;
  logic              w_rb_mono;

  // Ready drops as soon as the final sample is taken, while its write is still pending.
  assign o_s_ready   = (r_state == LOAD) && !r_load_last;
  assign w_accept    = i_s_valid && o_s_ready;
  assign w_mono_fail = CHECK_MONO && (r_cnt != {ADDR_W{1'b0}}) && (i_s_data < r_prev);
  assign w_issue     = (r_state == VERIFY) && !r_rd_last;
  assign w_tag_last  = w_tag_vld && (w_tag_addr == CNT_LAST);
  assign w_rb_next   = r_rb_sum + i_rd_data;
  assign w_rb_mono   = CHECK_MONO && (w_tag_addr != {ADDR_W{1'b0}}) && (i_rd_data < r_rb_prev);

  lut_rd_tag_pipe #(.ADDR_W(ADDR_W), .DEPTH(RD_LATENCY)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_start),
    .i_valid (w_issue),
    .i_addr  (r_rd_addr),
    .o_valid (w_tag_vld),
    .o_addr  (w_tag_addr)
  );

  // Loader FSM with write port, read address counter and both accumulators.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= {ADDR_W{1'b0}};
      r_load_last    <= 1'b0;
      r_prev         <= {DATA_W{1'b0}};
      r_checksum     <= {DATA_W{1'b0}};
      r_wr_en        <= 1'b0;
      r_wr_addr      <= {ADDR_W{1'b0}};
      r_wr_data      <= {DATA_W{1'b0}};
      r_rd_addr      <= {ADDR_W{1'b0}};
      r_rd_last      <= 1'b0;
      r_rb_sum       <= {DATA_W{1'b0}};
      r_rb_prev      <= {DATA_W{1'b0}};
      r_rb_mono_fail <= 1'b0;
    end else if (i_start) begin
      r_state        <= LOAD;
      r_cnt          <= {ADDR_W{1'b0}};
      r_load_last    <= 1'b0;
      r_prev         <= {DATA_W{1'b0}};
      r_checksum     <= {DATA_W{1'b0}};
      r_wr_en        <= 1'b0;
      r_rd_addr      <= {ADDR_W{1'b0}};
      r_rd_last      <= 1'b0;
      r_rb_sum       <= {DATA_W{1'b0}};
      r_rb_prev      <= {DATA_W{1'b0}};
      r_rb_mono_fail <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        LOAD: begin
          if (r_load_last) begin
            r_state <= VERIFY;
          end else if (w_accept) begin
            if (w_mono_fail) begin
              r_state <= ERR;
            end else begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_cnt;
              r_wr_data  <= i_s_data;
              r_checksum <= r_checksum + i_s_data;
              r_prev     <= i_s_data;
              if (r_cnt == CNT_LAST) r_load_last <= 1'b1;
              else                   r_cnt       <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            r_state <= LOAD;
          end
        end
        VERIFY: begin
          if (w_issue) begin
            if (r_rd_addr == CNT_LAST) r_rd_last <= 1'b1;
            else                       r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          if (w_tag_vld) begin
            r_rb_sum  <= w_rb_next;
            r_rb_prev <= i_rd_data;
            if (w_rb_mono) r_rb_mono_fail <= 1'b1;
          end
          // Final decision folds in the last returned word directly.
          if (w_tag_last) begin
            if ((w_rb_next == r_checksum) && !r_rb_mono_fail && !w_rb_mono) r_state <= DONE;
            else                                                            r_state <= ERR;
          end
        end
        IDLE, DONE, ERR: r_state <= r_state;
        default:         r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_addr   = r_rd_addr;
  assign o_checksum  = r_checksum;
  assign o_busy      = (r_state == LOAD) || (r_state == VERIFY);
  assign o_lut_valid = (r_state == DONE);
  assign o_error     = (r_state == ERR);
endmodule
